// File: rtl/uart_tx.sv
// Buffered 8N1/8N2 serial transmitter: 2**FIFO_AW-byte FIFO feeding a bit-timed shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
module uart_tx #(
  parameter int FIFO_AW   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        cfg_divider,
  input  logic               wr,
  input  logic [7:0]         wdata,
  output logic               ser_tx,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               overflow
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = (FIFO_AW)'(1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_d;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level_q;
  logic               push, pop;

  logic [31:0] div_q, baud_cnt, div_eff;
  logic [7:0]  shifter;
  logic [2:0]  bit_cnt;
  logic        tick, tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign push     = wr && !full;
  assign busy     = (state != IDLE);
  assign ser_tx   = tx_q;
  assign tick     = (baud_cnt == '0);
  assign div_eff  = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr && full;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // tx_d is derived from the current state and registered, so the line trails the FSM by one clock
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shifter[0];
        if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (tick && bit_cnt == LAST_STOP) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q     <= 1'b1;
      div_q    <= 32'd2;
      baud_cnt <= '0;
      shifter  <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (pop) begin
        div_q    <= div_eff;
        baud_cnt <= div_eff - 32'd1;
        shifter  <= mem[rd_ptr];
        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^mem[rd_ptr];
`endif
      end else if (state != IDLE) begin
        if (tick) begin
          baud_cnt <= div_q - 32'd1;
          if (state == DATA) shifter <= {1'b0, shifter[7:1]};
          bit_cnt  <= (state_d != state) ? '0 : bit_cnt + 3'd1;
        end else begin
          baud_cnt <= baud_cnt - 32'd1;
        end
      end
    end
  end

endmodule
